// File: rtl/classifier_mem_arb_if.sv
// Bus bundle for classifier_mem_arb: two lookup read ports, one CSR port and
// the single-port memory command/data path. The arbiter uses the slave modport.
interface classifier_mem_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              lk0_req_valid;
  logic              lk0_req_ready;
  logic [ADDR_W-1:0] lk0_req_addr;
  logic              lk0_rsp_valid;
  logic [DATA_W-1:0] lk0_rsp_data;

  logic              lk1_req_valid;
  logic              lk1_req_ready;
  logic [ADDR_W-1:0] lk1_req_addr;
  logic              lk1_rsp_valid;
  logic [DATA_W-1:0] lk1_rsp_data;

  logic              csr_req_valid;
  logic              csr_req_ready;
  logic              csr_req_wr;
  logic [ADDR_W-1:0] csr_req_addr;
  logic [DATA_W-1:0] csr_req_wdata;
  logic              csr_rsp_valid;
  logic [DATA_W-1:0] csr_rsp_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              init_done;

  modport slave (
    input  lk0_req_valid, lk0_req_addr,
    output lk0_req_ready, lk0_rsp_valid, lk0_rsp_data,
    input  lk1_req_valid, lk1_req_addr,
    output lk1_req_ready, lk1_rsp_valid, lk1_rsp_data,
    input  csr_req_valid, csr_req_wr, csr_req_addr, csr_req_wdata,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output init_done
  );

  modport master (
    output lk0_req_valid, lk0_req_addr,
    input  lk0_req_ready, lk0_rsp_valid, lk0_rsp_data,
    output lk1_req_valid, lk1_req_addr,
    input  lk1_req_ready, lk1_rsp_valid, lk1_rsp_data,
    output csr_req_valid, csr_req_wr, csr_req_addr, csr_req_wdata,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  init_done
  );
endinterface

// File: rtl/classifier_mem_arb.sv
// Single-port classifier memory arbiter: round-robin lookups, starvation-bounded CSR,
// fixed-latency read tag pipeline. Optional zeroing sweep: CLASSIFIER_MEM_INIT_EN.
module classifier_mem_arb #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 2,
  parameter int CSR_STARVE = 8
) (
  input logic                  cclk,
  input logic                  rst_n,
  classifier_mem_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(CSR_STARVE + 2);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(CSR_STARVE);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("classifier_mem_arb: RD_LAT must be within 1..4");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= STARVE_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic              init_ok;
  logic              sweep_wr;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef CLASSIFIER_MEM_INIT_EN
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} init_state_t;

  init_state_t       state;
  init_state_t       state_nxt;
  logic [ADDR_W-1:0] sweep_cnt;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == SWEEP) sweep_cnt <= sweep_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_wr  = 1'b0;
    case (state)
      IDLE:  state_nxt = SWEEP;
      SWEEP: begin
        sweep_wr = 1'b1;
        if (&sweep_cnt) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sweep_addr = sweep_cnt;
  assign init_ok    = (state == DONE);
`else
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) init_ok <= 1'b0;
    else        init_ok <= 1'b1;
  end

  assign sweep_wr   = 1'b0;
  assign sweep_addr = '0;
`endif

  logic             gnt_lk0;
  logic             gnt_lk1;
  logic             gnt_csr;
  logic             csr_force;
  logic             rr_last_lk1;
  logic [CNT_W-1:0] starve_cnt;

  assign csr_force = bus.csr_req_valid && (starve_cnt == STARVE_MAX);

  // A starved CSR overrides both lookups; otherwise lookups share round-robin.
  always_comb begin
    gnt_lk0 = 1'b0;
    gnt_lk1 = 1'b0;
    gnt_csr = 1'b0;
    if (init_ok) begin
      if (csr_force) begin
        gnt_csr = 1'b1;
      end else if (bus.lk0_req_valid && bus.lk1_req_valid) begin
        if (rr_last_lk1) gnt_lk0 = 1'b1;
        else             gnt_lk1 = 1'b1;
      end else if (bus.lk0_req_valid) begin
        gnt_lk0 = 1'b1;
      end else if (bus.lk1_req_valid) begin
        gnt_lk1 = 1'b1;
      end else if (bus.csr_req_valid) begin
        gnt_csr = 1'b1;
      end
    end
  end

  assign bus.lk0_req_ready = gnt_lk0;
  assign bus.lk1_req_ready = gnt_lk1;
  assign bus.csr_req_ready = gnt_csr;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_lk1 <= 1'b1;
      starve_cnt  <= '0;
    end else begin
      if (gnt_lk0)      rr_last_lk1 <= 1'b0;
      else if (gnt_lk1) rr_last_lk1 <= 1'b1;

      if (bus.csr_req_valid && !gnt_csr) starve_cnt <= sat_inc(starve_cnt);
      else                               starve_cnt <= '0;
    end
  end

  // Memory command, issued in the same cycle as the accepted request.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (sweep_wr) begin
      bus.mem_en   = 1'b1;
      bus.mem_wr   = 1'b1;
      bus.mem_addr = sweep_addr;
    end else if (gnt_lk0) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.lk0_req_addr;
    end else if (gnt_lk1) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.lk1_req_addr;
    end else if (gnt_csr) begin
      bus.mem_en   = 1'b1;
      bus.mem_wr   = bus.csr_req_wr;
      bus.mem_addr = bus.csr_req_addr;
      if (bus.csr_req_wr) bus.mem_wdata = bus.csr_req_wdata;
    end
  end

  // Read tag pipeline: one-hot {lk0, lk1, csr} per issued read, stage i = i+1 cycles old.
  logic [2:0] tag_p [RD_LAT];
  logic [2:0] tag_tail;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= {gnt_lk0, gnt_lk1, gnt_csr && !bus.csr_req_wr};
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Response stage: the tail tag steers mem_rdata; data is zero when not steered.
  assign tag_tail = tag_p[RD_LAT-1];

  assign bus.lk0_rsp_valid = tag_tail[2];
  assign bus.lk1_rsp_valid = tag_tail[1];
  assign bus.csr_rsp_valid = tag_tail[0];
  assign bus.lk0_rsp_data  = tag_tail[2] ? bus.mem_rdata : '0;
  assign bus.lk1_rsp_data  = tag_tail[1] ? bus.mem_rdata : '0;
  assign bus.csr_rsp_rdata = tag_tail[0] ? bus.mem_rdata : '0;

  assign bus.init_done = init_ok;

endmodule
